decode_stage: RTL

- Parametrised instruction-decode pipeline stage of the RISC core; sits between fetch and register-file read/execute.
- Splits each instruction into opcode, rs1, rs2 and rd fields.
- Detects two-word instructions and collects the trailing immediate word through a small FSM.
- Presents one registered decoded bundle to execute under valid/ready handshakes on both sides, with flush support.

---
 rtl/decode_pkg.sv | 20 ++
 rtl/decode_stage_instr_field_split.sv | 31 +++
 rtl/decode_stage.sv | 131 +++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Decode stage shared types: FSM state, default field widths and offsets.
package decode_pkg;

  typedef enum logic {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } dec_state_t;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_OPCODE_W = 5;
  localparam int DEF_RA_W     = 3;

  localparam logic [1:0] DEF_IMM_CLASS = 2'b10;

  localparam int DEF_OP_LSB  = DEF_WIDTH - DEF_OPCODE_W;
  localparam int DEF_RS1_LSB = DEF_OP_LSB - DEF_RA_W;
  localparam int DEF_RS2_LSB = DEF_RS1_LSB - DEF_RA_W;
  localparam int DEF_RD_LSB  = DEF_RS2_LSB - DEF_RA_W;

endpackage

// File: rtl/decode_stage_instr_field_split.sv
// Combinational instruction field splitter, shared with the hazard unit.
module instr_field_split
  import decode_pkg::*;
#(
  parameter int         WIDTH     = DEF_WIDTH,
  parameter int         OPCODE_W  = DEF_OPCODE_W,
  parameter int         RA_W      = DEF_RA_W,
  parameter logic [1:0] IMM_CLASS = DEF_IMM_CLASS
) (
  input  logic [WIDTH-1:0]    instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [RA_W-1:0]     rs1,
  output logic [RA_W-1:0]     rs2,
  output logic [RA_W-1:0]     rd,
  output logic                is_two_word
);

  localparam int OP_LSB  = WIDTH - OPCODE_W;
  localparam int RS1_LSB = OP_LSB - RA_W;
  localparam int RS2_LSB = RS1_LSB - RA_W;
  localparam int RD_LSB  = RS2_LSB - RA_W;

  // Shift-then-truncate keeps the ignored low bits out of the netlist.
  assign opcode = OPCODE_W'(instr >> OP_LSB);
  assign rs1    = RA_W'(instr >> RS1_LSB);
  assign rs2    = RA_W'(instr >> RS2_LSB);
  assign rd     = RA_W'(instr >> RD_LSB);

  assign is_two_word = (opcode[OPCODE_W-1 -: 2] == IMM_CLASS);

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: field split, two-word immediate collection,
// registered output bundle with valid/ready on both sides and flush.
module decode_stage
  import decode_pkg::*;
#(
  parameter int         WIDTH     = DEF_WIDTH,
  parameter int         OPCODE_W  = DEF_OPCODE_W,
  parameter int         RA_W      = DEF_RA_W,
  parameter logic [1:0] IMM_CLASS = DEF_IMM_CLASS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    instr,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic [RA_W-1:0]     rs1,
  output logic [RA_W-1:0]     rs2,
  output logic [RA_W-1:0]     rd,
  output logic                has_imm,
  output logic [WIDTH-1:0]    imm
);

  dec_state_t r_state, w_state_nxt;

  logic                r_out_valid;
  logic [OPCODE_W-1:0] r_opcode, r_pend_opcode;
  logic [RA_W-1:0]     r_rs1, r_rs2, r_rd;
  logic [RA_W-1:0]     r_pend_rs1, r_pend_rs2, r_pend_rd;
  logic                r_has_imm;
  logic [WIDTH-1:0]    r_imm;

  logic [OPCODE_W-1:0] w_opcode;
  logic [RA_W-1:0]     w_rs1, w_rs2, w_rd;
  logic                w_two;
  logic                w_accept, w_xfer;

  instr_field_split #(
    .WIDTH    (WIDTH),
    .OPCODE_W (OPCODE_W),
    .RA_W     (RA_W),
    .IMM_CLASS(IMM_CLASS)
  ) u_split (
    .instr      (instr),
    .opcode     (w_opcode),
    .rs1        (w_rs1),
    .rs2        (w_rs2),
    .rd         (w_rd),
    .is_two_word(w_two)
  );

  assign in_ready = !flush && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_xfer   = r_out_valid && out_ready;

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_OP;
    end else if (w_accept) begin
      unique case (r_state)
        S_OP:  w_state_nxt = w_two ? S_IMM : S_OP;
        S_IMM: w_state_nxt = S_OP;
        default: w_state_nxt = S_OP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_OP;
      r_out_valid   <= 1'b0;
      r_opcode      <= '0;
      r_rs1         <= '0;
      r_rs2         <= '0;
      r_rd          <= '0;
      r_has_imm     <= 1'b0;
      r_imm         <= '0;
      r_pend_opcode <= '0;
      r_pend_rs1    <= '0;
      r_pend_rs2    <= '0;
      r_pend_rd     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        r_out_valid   <= 1'b0;
        r_pend_opcode <= '0;
        r_pend_rs1    <= '0;
        r_pend_rs2    <= '0;
        r_pend_rd     <= '0;
      end else if (w_accept && r_state == S_IMM) begin
        r_opcode    <= r_pend_opcode;
        r_rs1       <= r_pend_rs1;
        r_rs2       <= r_pend_rs2;
        r_rd        <= r_pend_rd;
        r_has_imm   <= 1'b1;
        r_imm       <= instr;
        r_out_valid <= 1'b1;
      end else if (w_accept && w_two) begin
        r_pend_opcode <= w_opcode;
        r_pend_rs1    <= w_rs1;
        r_pend_rs2    <= w_rs2;
        r_pend_rd     <= w_rd;
        // Accept implies any held bundle is leaving this cycle.
        if (w_xfer) r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_opcode    <= w_opcode;
        r_rs1       <= w_rs1;
        r_rs2       <= w_rs2;
        r_rd        <= w_rd;
        r_has_imm   <= 1'b0;
        r_imm       <= '0;
        r_out_valid <= 1'b1;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign opcode    = r_opcode;
  assign rs1       = r_rs1;
  assign rs2       = r_rs2;
  assign rd        = r_rd;
  assign has_imm   = r_has_imm;
  assign imm       = r_imm;

endmodule
